// File: rtl/canny_window_driver.sv
// canny_window_driver
//   Host-side sequencer for the CannyEdge register-window core. Sweeps an
//   image held in external memory. For each 5x5 window it loads planes
//   X/Y/Z into the core over its bCE/bWE load port. It then pulses the
//   selected op via bOPEnable, reads OutData back, and writes one result
//   per window to a result memory.
//
//   Optional feature: define CANNY_DRV_PAD_EN to sweep every pixel as a
//   window centre. Out-of-image coordinates are then clamped to the image
//   border (replicate). When the macro is undefined, only fully-inside
//   windows are swept.
module canny_window_driver #(
  parameter int IMG_W     = 200,
  parameter int IMG_H     = 200,
  parameter int ADDR_W    = 16,
  parameter int OP_CYCLES = 4
) (
  input  logic              tclk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic [3:0]        read_sel,
  output logic              busy,
  output logic              done,
  output logic              img_rd,
  output logic [1:0]        img_plane,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_wdata,
  output logic [2:0]        dAddrRegRow,
  output logic [2:0]        dAddrRegCol,
  output logic [7:0]        InData,
  output logic [3:0]        dWriteReg,
  output logic              bCE,
  output logic              bWE,
  output logic [2:0]        OPMode,
  output logic              bOPEnable,
  output logic [3:0]        dReadReg,
  input  logic [7:0]        OutData
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRE, S_OP, S_RD, S_CAP, S_WR
  } state_t;

`ifdef CANNY_DRV_PAD_EN
  localparam int R_LAST = IMG_H - 1;
  localparam int C_LAST = IMG_W - 1;
`else
  localparam int R_LAST = IMG_H - 5;
  localparam int C_LAST = IMG_W - 5;
`endif

  localparam logic [ADDR_W-1:0] R_LAST_A = ADDR_W'(R_LAST);
  localparam logic [ADDR_W-1:0] C_LAST_A = ADDR_W'(C_LAST);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam int                OPC_W    = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam logic [OPC_W-1:0]  OP_LAST  = OPC_W'(OP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        mode_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] win_r, win_c;
  logic [2:0]        ld_row, ld_col;
  logic [1:0]        ld_plane;
  logic              ld_drain;
  logic [OPC_W-1:0]  op_cnt;
  logic              wr_valid;
  logic [2:0]        wr_row, wr_col;
  logic [1:0]        wr_plane;
  logic [7:0]        res_data_q;
  logic              done_q;

  logic              accept;
  logic              issue;
  logic              last_win;
  logic [1:0]        planes_last;
  logic [ADDR_W-1:0] px, py;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] res_addr_calc;

  assign accept   = (state_q == S_IDLE) && start && !mode[2];
  assign issue    = (state_q == S_LOAD) && !ld_drain;
  assign last_win = (win_r == R_LAST_A) && (win_c == C_LAST_A);

  // Index of the last plane loaded per window for the latched op mode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can leave it unassigned and infer a latch.
    planes_last = 2'd0;
    case (mode_q[1:0])
      2'd2:    planes_last = 2'd1;
      2'd3:    planes_last = 2'd2;
      default: planes_last = 2'd0;
    endcase
  end

`ifdef CANNY_DRV_PAD_EN
  localparam logic signed [ADDR_W+1:0] X_MAX = (ADDR_W+2)'(IMG_W - 1);
  localparam logic signed [ADDR_W+1:0] Y_MAX = (ADDR_W+2)'(IMG_H - 1);
  logic signed [ADDR_W+1:0] sx, sy;

  // Window centred on (r,c); each coordinate is clamped into the image.
  always_comb begin
    sx = $signed({2'b00, win_c}) + $signed({{(ADDR_W-1){1'b0}}, ld_col}) - (ADDR_W+2)'(2);
    sy = $signed({2'b00, win_r}) + $signed({{(ADDR_W-1){1'b0}}, ld_row}) - (ADDR_W+2)'(2);
    if (sx < 0)          px = '0;
    else if (sx > X_MAX) px = ADDR_W'(IMG_W - 1);
    else                 px = sx[ADDR_W-1:0];
    if (sy < 0)          py = '0;
    else if (sy > Y_MAX) py = ADDR_W'(IMG_H - 1);
    else                 py = sy[ADDR_W-1:0];
  end
`else
  // Window top-left at (r,c); every tap lies inside the image.
  always_comb begin
    px = win_c + ADDR_W'(ld_col);
    py = win_r + ADDR_W'(ld_row);
  end
`endif

  assign pix_addr      = py * IMG_W_A + px;
  assign res_addr_calc = win_r * IMG_W_A + win_c;

  // State register.
  always_ff @(posedge tclk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = S_LOAD;
        S_LOAD:  if (ld_drain) state_d = S_PRE;
        S_PRE:   state_d = S_OP;
        S_OP:    if (op_cnt == OP_LAST) state_d = S_RD;
        S_RD:    state_d = S_CAP;
        S_CAP:   state_d = S_WR;
        S_WR:    state_d = last_win ? S_IDLE : S_LOAD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sweep/load/op counters, load write pipeline, captured result and done pulse.
  always_ff @(posedge tclk or negedge rst_b) begin
    if (!rst_b) begin
      mode_q     <= '0;
      sel_q      <= '0;
      win_r      <= '0;
      win_c      <= '0;
      ld_row     <= '0;
      ld_col     <= '0;
      ld_plane   <= '0;
      ld_drain   <= 1'b0;
      op_cnt     <= '0;
      wr_valid   <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_plane   <= '0;
      res_data_q <= '0;
      done_q     <= 1'b0;
    end else if (abort) begin
      ld_row   <= '0;
      ld_col   <= '0;
      ld_plane <= '0;
      ld_drain <= 1'b0;
      op_cnt   <= '0;
      wr_valid <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      // Pixel read issued this cycle returns next cycle and is written into the core then.
      wr_valid <= issue;
      if (issue) begin
        wr_row   <= ld_row;
        wr_col   <= ld_col;
        wr_plane <= ld_plane;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            mode_q <= mode;
            sel_q  <= read_sel;
            win_r  <= '0;
            win_c  <= '0;
          end
        end
        S_LOAD: begin
          if (issue) begin
            if (ld_col == 3'd4) begin
              ld_col <= '0;
              if (ld_row == 3'd4) begin
                ld_row <= '0;
                if (ld_plane == planes_last) begin
                  ld_plane <= '0;
                  ld_drain <= 1'b1;
                end else begin
                  ld_plane <= ld_plane + 2'd1;
                end
              end else begin
                ld_row <= ld_row + 3'd1;
              end
            end else begin
              ld_col <= ld_col + 3'd1;
            end
          end else begin
            ld_drain <= 1'b0;
          end
        end
        S_OP:  op_cnt <= (op_cnt == OP_LAST) ? '0 : op_cnt + OPC_W'(1);
        S_CAP: res_data_q <= OutData;
        S_WR: begin
          if (last_win) begin
            done_q <= 1'b1;
          end else if (win_c == C_LAST_A) begin
            win_c <= '0;
            win_r <= win_r + ADDR_W'(1);
          end else begin
            win_c <= win_c + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: memory strobes and core port driven from state and load pipeline.
  always_comb begin
    busy        = 1'b0;
    done        = done_q;
    img_rd      = 1'b0;
    img_plane   = '0;
    img_addr    = '0;
    res_we      = 1'b0;
    res_addr    = '0;
    res_wdata   = '0;
    dAddrRegRow = '0;
    dAddrRegCol = '0;
    InData      = '0;
    dWriteReg   = '0;
    bCE         = 1'b1;
    bWE         = 1'b1;
    OPMode      = '0;
    bOPEnable   = 1'b1;
    dReadReg    = '0;
    if (state_q != S_IDLE) begin
      busy   = 1'b1;
      OPMode = mode_q;
    end
    if (issue) begin
      img_rd    = 1'b1;
      img_plane = ld_plane;
      img_addr  = pix_addr;
    end
    if (wr_valid) begin
      bCE         = 1'b0;
      bWE         = 1'b0;
      dAddrRegRow = wr_row;
      dAddrRegCol = wr_col;
      InData      = img_rdata;
      dWriteReg   = {2'b00, wr_plane};
    end
    case (state_q)
      S_OP:  bOPEnable = 1'b0;
      S_RD: begin
        bCE      = 1'b0;
        dReadReg = sel_q;
      end
      S_WR: begin
        res_we    = 1'b1;
        res_addr  = res_addr_calc;
        res_wdata = res_data_q;
      end
      default: ;
    endcase
  end

endmodule
